// File: rtl/pwm_pkg.sv
// Shared types and defaults for the multi-channel PWM generator.
package pwm_pkg;

   localparam int PWM_CH_DEFAULT = 4;
   localparam int PWM_W_DEFAULT  = 8;

   typedef enum logic {
      PWM_EDGE   = 1'b0,
      PWM_CENTER = 1'b1
   } pwm_mode_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } pwm_dir_t;

   // Bit offset of channel i's duty field inside the packed duty bus.
   function automatic int duty_slice(input int i, input int w);
      return i * w;
   endfunction

endpackage

// File: rtl/pwm_chan_cmp.sv
// One PWM channel: shadow and active duty, plus the registered compare output.
module pwm_chan_cmp
   import pwm_pkg::*;
#(
   parameter int W = PWM_W_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         load,
   input  logic         xfer,
   input  logic [W-1:0] cnt,
   input  logic [W-1:0] duty_in,
   output logic         pwm_out
);

   logic [W-1:0] d_act_q, d_act_d;
   logic [W-1:0] d_sh_q, d_sh_d;
   logic         out_q, out_d;

   // Compare against the duty active this cycle; transfer and capture take effect next cycle.
   always_comb begin
      d_act_d = d_act_q;
      d_sh_d  = d_sh_q;
      out_d   = 1'b0;
      if (en) begin
         out_d = (cnt < d_act_q);
      end
      if (xfer) begin
         d_act_d = d_sh_q;
      end
      if (load) begin
         d_sh_d = duty_in;
      end
   end

   // Channel state register; the output drops immediately when reset asserts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d_act_q <= '0;
         d_sh_q  <= '0;
         out_q   <= 1'b0;
      end else begin
         d_act_q <= d_act_d;
         d_sh_q  <= d_sh_d;
         out_q   <= out_d;
      end
   end

   assign pwm_out = out_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// N-channel PWM generator sharing one period counter, edge- or centre-aligned,
// with period/duty/mode double-buffered so changes land only on a period boundary.
module pwm_multi_channel
   import pwm_pkg::*;
#(
   parameter int CH = PWM_CH_DEFAULT,
   parameter int W  = PWM_W_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          load,
   input  logic [W-1:0]  period,
   input  logic [CH*W-1:0] duty,
   input  logic          center,
   output logic [CH-1:0] pwm_out,
   output logic          period_tick,
   output logic          busy
);

   localparam logic [W-1:0] CNT_ONE = W'(1);

   logic [W-1:0] cnt_q, cnt_d;
   pwm_dir_t     dir_q, dir_d;
   logic [W-1:0] per_act_q, per_act_d;
   logic [W-1:0] per_sh_q, per_sh_d;
   pwm_mode_t    mode_act_q, mode_act_d;
   pwm_mode_t    mode_sh_q, mode_sh_d;
   logic         busy_q, busy_d;
   logic         tick_q, tick_d;

   logic         boundary;
   logic         xfer;
   logic [W-1:0] per_eff;
   pwm_mode_t    mode_eff;

   // Shadow handling and counter stepping; the step after a transfer already uses the new period and mode.
   always_comb begin
      cnt_d      = cnt_q;
      dir_d      = dir_q;
      per_act_d  = per_act_q;
      per_sh_d   = per_sh_q;
      mode_act_d = mode_act_q;
      mode_sh_d  = mode_sh_q;

      boundary = en && (cnt_q == '0);
      xfer     = busy_q && (boundary || !en);
      per_eff  = xfer ? per_sh_q : per_act_q;
      mode_eff = xfer ? mode_sh_q : mode_act_q;

      if (xfer) begin
         per_act_d  = per_sh_q;
         mode_act_d = mode_sh_q;
      end
      if (load) begin
         per_sh_d  = period;
         mode_sh_d = pwm_mode_t'(center);
      end
      busy_d = load || (busy_q && !xfer);
      tick_d = boundary;

      if (!en || xfer) begin
         dir_d = DIR_UP;
      end

      if (!en) begin
         cnt_d = '0;
      end else if (mode_eff == PWM_EDGE) begin
         dir_d = DIR_UP;
         cnt_d = (cnt_q >= per_eff) ? '0 : cnt_q + CNT_ONE;
      end else if (cnt_q == '0) begin
         dir_d = DIR_UP;
         cnt_d = (per_eff == '0) ? '0 : CNT_ONE;
      end else if ((dir_q == DIR_UP) && (cnt_q < per_eff)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         dir_d = DIR_DOWN;
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   // Shared counter, period/mode registers, pending flag and boundary pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q      <= '0;
         dir_q      <= DIR_UP;
         per_act_q  <= '1;
         per_sh_q   <= '1;
         mode_act_q <= PWM_EDGE;
         mode_sh_q  <= PWM_EDGE;
         busy_q     <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         dir_q      <= dir_d;
         per_act_q  <= per_act_d;
         per_sh_q   <= per_sh_d;
         mode_act_q <= mode_act_d;
         mode_sh_q  <= mode_sh_d;
         busy_q     <= busy_d;
         tick_q     <= tick_d;
      end
   end

   genvar g;
   generate
      for (g = 0; g < CH; g++) begin : g_chan
         pwm_chan_cmp #(.W(W)) u_chan (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .load    (load),
            .xfer    (xfer),
            .cnt     (cnt_q),
            .duty_in (duty[duty_slice(g, W) +: W]),
            .pwm_out (pwm_out[g])
         );
      end
   endgenerate

   assign period_tick = tick_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed plus randomized bench for pwm_multi_channel against a phase-based reference model.
module tb_pwm_multi_channel;

   localparam int CH = 4;
   localparam int W  = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            en;
   logic            load;
   logic [W-1:0]    period;
   logic [CH*W-1:0] duty;
   logic            center;
   logic [CH-1:0]   pwm_out;
   logic            period_tick;
   logic            busy;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: active/shadow configuration plus the position k within the current period.
   int            mP, sP;
   bit            mC, sC;
   int            mD[CH];
   int            sD[CH];
   bit            mBusy;
   int            k;
   logic [CH-1:0] expOut;
   logic          expTick;

   int hiCnt[CH];
   int tickCnt;

   pwm_multi_channel #(.CH(CH), .W(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .load        (load),
      .period      (period),
      .duty        (duty),
      .center      (center),
      .pwm_out     (pwm_out),
      .period_tick (period_tick),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   function automatic int periodLen(input int p, input bit c);
      if (!c) return p + 1;
      return (p == 0) ? 1 : 2 * p;
   endfunction

   function automatic int cntOf(input int kk, input int p, input bit c);
      if (!c) return kk;
      return (kk <= p) ? kk : 2 * p - kk;
   endfunction

   task automatic modelReset();
      mP = (1 << W) - 1;
      sP = (1 << W) - 1;
      mC = 1'b0;
      sC = 1'b0;
      for (int i = 0; i < CH; i++) begin
         mD[i] = 0;
         sD[i] = 0;
      end
      mBusy   = 1'b0;
      k       = 0;
      expOut  = '0;
      expTick = 1'b0;
   endtask

   // Advances the model by one clock using the inputs currently driven.
   task automatic modelStep();
      int  cv;
      bit  xf;
      cv = cntOf(k, mP, mC);
      for (int i = 0; i < CH; i++) begin
         expOut[i] = en && (cv < mD[i]);
      end
      expTick = en && (k == 0);
      xf = mBusy && (!en || (k == 0));
      if (xf) begin
         mP = sP;
         mC = sC;
         for (int i = 0; i < CH; i++) mD[i] = sD[i];
      end
      if (load) begin
         sP = int'(period);
         sC = center;
         for (int i = 0; i < CH; i++) sD[i] = int'(duty[i*W +: W]);
      end
      mBusy = load || (mBusy && !xf);
      k = en ? ((k + 1) % periodLen(mP, mC)) : 0;
   endtask

   task automatic checkOutput();
      vectors++;
      assert (pwm_out === expOut) else begin
         miscompares++;
         $error("[TB] FAIL pwm_out observed=%b expected=%b t=%0t", pwm_out, expOut, $time);
      end
      vectors++;
      assert (period_tick === expTick) else begin
         miscompares++;
         $error("[TB] FAIL period_tick observed=%b expected=%b t=%0t", period_tick, expTick, $time);
      end
      vectors++;
      assert (busy === mBusy) else begin
         miscompares++;
         $error("[TB] FAIL busy observed=%b expected=%b t=%0t", busy, mBusy, $time);
      end
      for (int i = 0; i < CH; i++) hiCnt[i] += int'(pwm_out[i]);
      tickCnt += int'(period_tick);
   endtask

   task automatic checkValue(input string tag, input int observed, input int expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic clearCounts();
      for (int i = 0; i < CH; i++) hiCnt[i] = 0;
      tickCnt = 0;
   endtask

   // One clock: model first, then the edge, then compare just after it; load is a single-cycle strobe.
   task automatic applyStimulus();
      modelStep();
      @(posedge clk);
      #1;
      checkOutput();
      load = 1'b0;
   endtask

   task automatic setCfg(input int p, input bit c, input int d0, input int d1, input int d2, input int d3);
      period = W'(p);
      center = c;
      duty   = {W'(d3), W'(d2), W'(d1), W'(d0)};
      load   = 1'b1;
   endtask

   // Loads a configuration with the counter stopped so it becomes active right away, then runs.
   task automatic configureStopped(input int p, input bit c, input int d0, input int d1, input int d2, input int d3);
      en = 1'b0;
      setCfg(p, c, d0, d1, d2, d3);
      applyStimulus();
      applyStimulus();
      en = 1'b1;
   endtask

   task automatic runUntilPhase(input int target);
      for (int n = 0; (n < 600) && (k != target); n++) applyStimulus();
   endtask

   initial begin
      reset  = 1'b0;
      en     = 1'b0;
      load   = 1'b0;
      period = '0;
      duty   = '0;
      center = 1'b0;
      clearCounts();
      modelReset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput();
      reset = 1'b1;

      // Edge mode, P=9, D={0,3,10,255}
      configureStopped(9, 1'b0, 0, 3, 10, 255);
      repeat (5) applyStimulus();
      clearCounts();
      repeat (10) applyStimulus();
      checkValue("edge_out0_high", hiCnt[0], 0);
      checkValue("edge_out1_high", hiCnt[1], 3);
      checkValue("edge_out2_high", hiCnt[2], 10);
      checkValue("edge_out3_high", hiCnt[3], 10);
      checkValue("edge_ticks", tickCnt, 1);

      // Centre mode, P=4, D0=2
      configureStopped(4, 1'b1, 2, 0, 0, 0);
      repeat (3) applyStimulus();
      clearCounts();
      repeat (8) applyStimulus();
      checkValue("centre_out0_high", hiCnt[0], 3);
      checkValue("centre_ticks", tickCnt, 1);

      // Load mid-period: current period keeps the old duty
      configureStopped(9, 1'b0, 3, 0, 0, 0);
      runUntilPhase(4);
      setCfg(9, 1'b0, 6, 0, 0, 0);
      applyStimulus();
      checkValue("busy_after_load", int'(busy), 1);
      runUntilPhase(0);
      clearCounts();
      repeat (10) applyStimulus();
      checkValue("new_duty_high", hiCnt[0], 6);

      // Load on the boundary cycle: applies one period later
      runUntilPhase(0);
      setCfg(9, 1'b0, 2, 0, 0, 0);
      applyStimulus();
      clearCounts();
      repeat (10) applyStimulus();
      checkValue("boundary_load_old_duty", hiCnt[0], 6);
      clearCounts();
      repeat (10) applyStimulus();
      checkValue("boundary_load_new_duty", hiCnt[0], 2);

      // Enable drop with a load pending
      runUntilPhase(3);
      setCfg(9, 1'b0, 8, 0, 0, 0);
      applyStimulus();
      runUntilPhase(5);
      en = 1'b0;
      applyStimulus();
      checkValue("disable_out", int'(pwm_out), 0);
      checkValue("disable_busy", int'(busy), 0);
      en = 1'b1;
      clearCounts();
      repeat (10) applyStimulus();
      checkValue("reenable_duty_high", hiCnt[0], 8);

      // Reset mid-period in centre mode
      configureStopped(20, 1'b1, 15, 30, 0, 0);
      repeat (7) applyStimulus();
      #2;
      reset = 1'b0;
      #1;
      checkValue("async_reset_out", int'(pwm_out), 0);
      modelReset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (3) applyStimulus();
      checkValue("post_reset_busy", int'(busy), 0);

      // Randomized operation
      for (int n = 0; n < 1500; n++) begin
         en = ($urandom_range(0, 99) < 96);
         if ($urandom_range(0, 24) == 0) begin
            period = ($urandom_range(0, 7) == 0) ? W'(255) : W'($urandom_range(0, 12));
            center = 1'($urandom_range(0, 1));
            for (int i = 0; i < CH; i++) begin
               duty[i*W +: W] = ($urandom_range(0, 9) == 0) ? W'(255) : W'($urandom_range(0, 15));
            end
            load = 1'b1;
         end
         applyStimulus();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
